// File: rtl/packet_page_releaser.sv
// packet_page_releaser: walks a stored packet's page chain, offers each page to the read engine, then frees it
// Ports: start_* (scheduler request), link_rd_* (link RAM read port), page_* (read engine handshake),
//        free_push/free_addr (free-list push_tail/tail_addr), done (last page freed), err_zero (zero-length start)
module packet_page_releaser #(
   parameter int ADDR_W = 11,
   parameter int CNT_W  = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [ADDR_W-1:0] start_head,
   input  logic [CNT_W-1:0]  start_count,
   output logic              link_rd_en,
   output logic [ADDR_W-1:0] link_rd_addr,
   input  logic [ADDR_W-1:0] link_rd_data,
   output logic              page_valid,
   input  logic              page_ready,
   output logic [ADDR_W-1:0] page_addr,
   output logic              page_last,
   output logic              free_push,
   output logic [ADDR_W-1:0] free_addr,
   output logic              done,
   output logic              err_zero
);
   typedef enum logic [1:0] {IDLE, FETCH, OFFER} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d, nxt_q, nxt_d, free_addr_q, free_addr_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic              cap_q, cap_d, free_push_q, free_push_d, done_q, done_d, err_zero_q, err_zero_d;
   logic              start_acc, page_acc, start_go;
   assign start_acc = start_valid && start_ready;
   assign page_acc  = page_valid && page_ready;
   assign start_go  = start_acc && start_count != '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      if (state_q == IDLE && start_go)
         state_d = start_count == CNT_W'(1) ? OFFER : FETCH;
      else if (state_q == FETCH)
         state_d = OFFER;
      else if (state_q == OFFER && page_acc)
         state_d = rem_q == CNT_W'(1) ? IDLE : (rem_q > CNT_W'(2) ? FETCH : OFFER);
   end
   always_comb begin
      start_ready  = state_q == IDLE;
      link_rd_en   = state_q == FETCH;
      link_rd_addr = state_q == FETCH ? cur_q : '0;
      page_valid   = state_q == OFFER;
      page_addr    = state_q == OFFER ? cur_q : '0;
      page_last    = state_q == OFFER && rem_q == CNT_W'(1);
      free_push    = free_push_q;
      free_addr    = free_addr_q;
      done         = done_q;
      err_zero     = err_zero_q;
   end
   // cap_q marks the first OFFER cycle after a FETCH, when link_rd_data carries the next pointer;
   // nxt_d forwards it so an accept in that very cycle advances straight to the next page.
   always_comb begin
      cap_d       = state_q == FETCH;
      nxt_d       = cap_q ? link_rd_data : nxt_q;
      cur_d       = start_go ? start_head : cur_q;
      rem_d       = start_go ? start_count : rem_q;
      free_push_d = page_acc;
      free_addr_d = page_acc ? cur_q : free_addr_q;
      done_d      = page_acc && rem_q == CNT_W'(1);
      err_zero_d  = start_acc && start_count == '0;
      if (page_acc && rem_q != CNT_W'(1)) begin
         cur_d = nxt_d;
         rem_d = rem_q - CNT_W'(1);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_q       <= '0;
         nxt_q       <= '0;
         rem_q       <= '0;
         cap_q       <= 1'b0;
         free_push_q <= 1'b0;
         free_addr_q <= '0;
         done_q      <= 1'b0;
         err_zero_q  <= 1'b0;
      end else begin
         cur_q       <= cur_d;
         nxt_q       <= nxt_d;
         rem_q       <= rem_d;
         cap_q       <= cap_d;
         free_push_q <= free_push_d;
         free_addr_q <= free_addr_d;
         done_q      <= done_d;
         err_zero_q  <= err_zero_d;
      end
   end
endmodule

// File: doc/packet_page_releaser.md
Name: packet_page_releaser

Overview:
- Dequeue-side counterpart of the null-page free list: given a stored packet's head page and page count, walks the page link RAM and presents each page to the read engine in order.
- Once the read engine has consumed a page, returns it to the free list through that list's push_tail/tail_addr interface.
- Sits between the output scheduler (start request), the link RAM read port, the packet read engine and fifo_null_pages.

Parameters:
ADDR_W, 11, page address width; must match the free-list address width.
CNT_W, 7, page-count width; counts 1..2^CNT_W-1 are legal.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  scheduler offers a packet to release
start_ready  out  1  block idle and able to accept a packet
start_head  in  ADDR_W  first page of the packet
start_count  in  CNT_W  number of pages in the packet
link_rd_en  out  1  link RAM read strobe
link_rd_addr  out  ADDR_W  page whose next pointer is read
link_rd_data  in  ADDR_W  next-page pointer, valid the cycle after link_rd_en
page_valid  out  1  page_addr valid toward the read engine
page_ready  in  1  read engine accepts the page
page_addr  out  ADDR_W  current page
page_last  out  1  current page is the packet's last
free_push  out  1  push a freed page to the free list (drives push_tail)
free_addr  out  ADDR_W  freed page (drives tail_addr)
done  out  1  one-cycle pulse with the free_push of the last page
err_zero  out  1  one-cycle pulse: start accepted with count 0

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; start_ready=1; all other outputs 0; internal cur/next/remaining regs 0.
- Reset mid-packet: block aborts to IDLE; unreleased pages are not pushed. Higher-level reset also reinitialises the free list.
- Handshakes: start accepted when start_valid && start_ready. Page accepted when page_valid && page_ready.
- page_valid, once high, holds with stable page_addr/page_last until accepted.
- start_ready = (state==IDLE).

States:
- IDLE, on start accept:
  - count==0 -> err_zero pulse next cycle, stay IDLE.
  - count==1 -> cur=head, remaining=1, go OFFER. page_valid high 1 cycle after accept.
  - count>1 -> cur=head, remaining=count, go FETCH.
- FETCH: link_rd_en=1, link_rd_addr=cur for exactly one cycle, go OFFER.
- OFFER: page_valid=1, page_addr=cur, page_last=(remaining==1).
  - If the previous state was FETCH, capture next=link_rd_data this cycle.
  - On accept with remaining>1: cur=next (use link_rd_data directly if accept is in the capture cycle), remaining-1, go FETCH if remaining-1>1, else go OFFER.
  - On accept with remaining==1: go IDLE.

Latency and ordering:
- Multi-page first page_valid occurs 2 cycles after start accept.
- Minimum spacing between non-last pages is 2 cycles: FETCH plus one OFFER cycle with immediate accept.
- Freeing: free_push is registered. It pulses 1 cycle after each page accept, with free_addr = the accepted page.
- A page is never pushed before its next pointer has been read. This guarantees the writer cannot reuse and overwrite a page's link entry before it has been read.
- done pulses in the same cycle as the last free_push. start_ready returns the cycle after the last accept, so a new start may be accepted in the same cycle as the previous packet's done.
- free_push is at most one pulse per cycle and needs no backpressure; the free list always has room for pages it issued.
- remaining decrements in CNT_W bits and never wraps, because it is only decremented while >1 in the looping branch.
- page_addr/cur are ADDR_W wide, and link pointers are used unchecked. Page 2^ADDR_W-1 is a valid page.

Test Plan:
- Single page: start head=5 count=1, page_ready=1 -> page_valid cycle+1 with addr 5, last=1; free_push addr 5 and done cycle+2; no link_rd_en.
- Three-page chain: link[10]=20, link[20]=7, start head=10 count=3, ready=1 -> link reads 10, 20; pages 10, 20, 7 with last only on 7; free_push 10, 20, 7 in order; done with 7.
- Backpressure: same chain, page_ready low 5 cycles on page 20 -> page_addr stays 20, no extra link read, no free_push until accept, final order unchanged.
- Zero count: start count=0 -> err_zero pulse, no page_valid, no free_push, start_ready stays 1.
- Back-to-back: second start (head=2047 count=2, link[2047]=0) presented during the first packet's last accept -> accepted the following cycle; pages 2047, 0 emitted and freed.
- Reset mid-packet: assert rst_n low after the first of 3 pages is freed -> all outputs 0 immediately, start_ready=1 after release, remaining pages are not pushed.
